ahb_regfile_slave: RTL and testbench
====================================

Name: ahb_regfile_slave

Overview:
Parametrised AHB-Lite slave with an integrated register file.
- Next generation of the team's slave/register-file pair: one module with a full address/data-phase pipeline.
- Adds configurable data width and depth, byte-lane writes from HSIZE, programmable wait states, and a two-cycle ERROR response for illegal accesses.
- Sits on the AHB interconnect as a peripheral control/status register bank.

Parameters:
ADDR_WIDTH, 8, HADDR width in bits
DATA_WIDTH, 32, HWDATA/HRDATA width; must be 8, 16, 32 or 64
DEPTH, 16, number of DATA_WIDTH-bit registers; 2 to 2^(ADDR_WIDTH-log2(DATA_WIDTH/8))
WAIT_STATES, 0, HREADYOUT-low cycles inserted before completing each OKAY transfer; 0 to 15

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  ADDR_WIDTH  byte address
HWRITE  in  1  1 = write, 0 = read
HSIZE  in  3  transfer size (byte/half/word/dword)
HBURST  in  3  burst type; accepted, not decoded
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HWDATA  in  DATA_WIDTH  write data, data phase
HREADY  in  1  bus-level ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  DATA_WIDTH  read data

Behaviour:
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, all registers 0, FSM=IDLE, address-phase registers cleared. Reset mid-transfer aborts the transfer and drops pending writes.
- Address-phase acceptance: HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ).
  - On acceptance, capture HADDR, HWRITE and HSIZE.
- IDLE/BUSY or unselected transfers: zero-wait OKAY, no register side effect.
- Word index = HADDR[ADDR_WIDTH-1:LSB], where LSB = log2(DATA_WIDTH/8).
- Error conditions, checked at acceptance:
  - index >= DEPTH
  - HSIZE > LSB
  - HADDR not aligned to 2^HSIZE
- FSM states: IDLE, WAIT, OKAY, ERR1, ERR2.
  - IDLE: HREADYOUT=1. Accepted legal transfer → WAIT if WAIT_STATES>0, else OKAY. Illegal transfer → ERR1.
  - WAIT: HREADYOUT=0. Counter runs WAIT_STATES cycles, then → OKAY.
  - OKAY: HREADYOUT=1, HRESP=0; the data phase completes here.
    - Writes commit at the end of this cycle. Byte lanes are enabled per HSIZE and the address low bits; unselected lanes keep their old value.
    - Reads drive HRDATA = reg[index] for this cycle; HRDATA=0 outside read data phases.
    - A new accepted transfer in the same cycle starts its own pipeline (back-to-back allowed); otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, no write performed.
  - ERR2: HREADYOUT=1, HRESP=1, then → IDLE, or start the new transfer if one is accepted in ERR2.
- Read-after-write to the same register, back-to-back: the read returns the new value. The write commits at the edge that ends its data phase, before the read data phase.
- A new address phase is only accepted while HREADY=1, so nothing is captured while the slave is stalling.
- HBURST is ignored; each beat is treated independently. SEQ after an ERROR is treated as a fresh access.

Optional Feature:
Macro AHB_SLV_RO_REGION_EN.
- Defined: registers with index >= DEPTH/2 are read-only. A write to them gets a two-cycle ERROR and no update. Reads are unaffected.
- Undefined: all registers are read/write. No RO logic is generated.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - HSIZE encodings
  - HRESP_OKAY/HRESP_ERROR
  - FSM state typedef
  - clog2-based LSB helper constant
- Sub-module ahb_byte_lane_mask: combinational; inputs HSIZE, HADDR low bits; output DATA_WIDTH/8 write strobes.

Test Plan:
- DATA_WIDTH=32, WAIT_STATES=0: word write 0xDEADBEEF to 0x04, then read 0x04 → HRDATA=0xDEADBEEF, HRESP=0, no stall.
- Byte write 0xAA to 0x06 (HSIZE=0) over 0x11223344 → read 0x04 returns 0x11AA3344.
- Read at index DEPTH (0x40) → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), registers unchanged.
- WAIT_STATES=3: single read → exactly 3 cycles HREADYOUT=0, then data with OKAY.
- Back-to-back write 0x5A5A5A5A to 0x08 then read 0x08 (pipelined) → read returns 0x5A5A5A5A.
- HRESETn pulsed low during WAIT → HREADYOUT=1 and HRESP=0 immediately; subsequent read of any register returns 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the register-file slave.
// The optional read-only upper region is enabled with AHB_SLV_RO_REGION_EN.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_OKAY,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Number of byte-offset address bits inside one data word.
  function automatic int lane_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/ahb_byte_lane_mask.sv
// Byte-lane write strobes from HSIZE and the low address bits of the beat.
module ahb_byte_lane_mask
  import ahb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int LSB        = lane_lsb(DATA_WIDTH),
  localparam int LO_W       = (LSB == 0) ? 1 : LSB
) (
  input  logic [2:0]      size,
  input  logic [LO_W-1:0] addr_lo,
  output logic [NB-1:0]   strb
);

  int nbytes;
  int base;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    nbytes = 0;
    strb   = '0;
    case (size)
      HSIZE_BYTE:  nbytes = 1;
      HSIZE_HALF:  nbytes = 2;
      HSIZE_WORD:  nbytes = 4;
      HSIZE_DWORD: nbytes = 8;
      default:     nbytes = 0;
    endcase
    // Masking with NB-1 keeps an 8-bit bus (no offset bits) on lane 0.
    base = int'(addr_lo) & (NB - 1);
    for (int i = 0; i < NB; i++) begin
      if (i >= base && i < base + nbytes) strb[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_regfile_slave.sv
// AHB-Lite slave with an integrated register file, wait states and 2-cycle ERROR.
// Define AHB_SLV_RO_REGION_EN to make the upper half of the registers read-only.
module ahb_regfile_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LSB    = lane_lsb(DATA_WIDTH);
  localparam int LO_W   = (LSB == 0) ? 1 : LSB;
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int RIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                state, state_n, start_state;
  logic [3:0]            wait_cnt;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [LO_W-1:0]       lo_q;
  logic [RIDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]      idx_full;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  accept, take, illegal, do_write;
  logic [NB-1:0]         strb;
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Burst type and the NONSEQ/SEQ distinction do not affect behaviour.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  assign idx_full   = HADDR[ADDR_WIDTH-1:LSB];
  assign align_mask = ADDR_WIDTH'((32'd1 << HSIZE) - 32'd1);
  assign accept     = HSEL && HREADY && HTRANS[1];
  // A new address phase can only land while no data phase is stalling.
  assign take       = accept && (state inside {ST_IDLE, ST_OKAY, ST_ERR2});
  assign do_write   = (state == ST_OKAY) && write_q;

  always_comb begin
    illegal = (32'(idx_full) >= 32'(DEPTH))
           || (32'(HSIZE) > 32'(LSB))
           || ((HADDR & align_mask) != '0);
`ifdef AHB_SLV_RO_REGION_EN
    if (HWRITE && (32'(idx_full) >= 32'(DEPTH / 2))) illegal = 1'b1;
`endif
    if (illegal)              start_state = ST_ERR1;
    else if (WAIT_STATES > 0) start_state = ST_WAIT;
    else                      start_state = ST_OKAY;
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_OKAY, ST_ERR2: state_n = take ? start_state : ST_IDLE;
      ST_WAIT:                   if (wait_cnt == '0) state_n = ST_OKAY;
      ST_ERR1:                   state_n = ST_ERR2;
      default:                   state_n = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    HREADYOUT = !(state inside {ST_WAIT, ST_ERR1});
    HRESP     = (state inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    HRDATA    = '0;
    if (state == ST_OKAY && !write_q) HRDATA = regs[idx_q];
  end

  // Wait counter: loaded on entry to WAIT, ends the stall when it reaches zero.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                                   wait_cnt <= '0;
    else if (state_n == ST_WAIT && state != ST_WAIT) wait_cnt <= 4'(WAIT_STATES - 1);
    else if (state == ST_WAIT)                      wait_cnt <= wait_cnt - 4'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      write_q <= 1'b0;
      size_q  <= '0;
      lo_q    <= '0;
      idx_q   <= '0;
    end else if (take) begin
      write_q <= HWRITE;
      size_q  <= HSIZE;
      lo_q    <= HADDR[LO_W-1:0];
      idx_q   <= idx_full[RIDX_W-1:0];
    end
  end

  ahb_byte_lane_mask #(.DATA_WIDTH(DATA_WIDTH)) u_mask (
    .size    (size_q),
    .addr_lo (lo_q),
    .strb    (strb)
  );

  // Writes commit at the edge that ends the OKAY data phase, so a pipelined
  // read of the same register in the next beat already sees the new value.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: this bank is flops with a defined reset value, not a RAM macro,
    // so clearing every entry on reset is intended.
    if (!HRESETn) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (strb[b]) regs[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_regfile_slave.sv
// Directed bench: a zero-wait instance (dut0) and a 3-wait-state instance (dut1).
module tb_ahb_regfile_slave;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  hsel;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hreadyout0, hresp0, hreadyout1, hresp1;
  logic [31:0] hrdata0, hrdata1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rdat;
  logic        rsp, frdy, fresp;
  int          stalls;

  always #5 clk = ~clk;

  ahb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
    .HREADY(hreadyout0), .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0)
  );

  ahb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(3)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
    .HREADY(hreadyout1), .HREADYOUT(hreadyout1), .HRESP(hresp1), .HRDATA(hrdata1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single non-pipelined transfer; reports first data-phase cycle and completion.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic resp_o,
                      output logic first_rdy, output logic first_resp, output int n_stall);
    logic done, r_s, p_s;
    @(posedge clk); #1;
    hsel = '0; hsel[d] = 1'b1;
    htrans = HTRANS_NONSEQ; haddr = a; hwrite = wr; hsize = sz;
    @(posedge clk); #1;
    hsel = '0; htrans = HTRANS_IDLE; hwdata = wd;
    done = 1'b0; n_stall = 0; rd = '0; resp_o = 1'b0; first_rdy = 1'b0; first_resp = 1'b0;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      r_s = (d == 1) ? hreadyout1 : hreadyout0;
      p_s = (d == 1) ? hresp1 : hresp0;
      if (i == 0) begin first_rdy = r_s; first_resp = p_s; end
      if (r_s) begin
        done = 1'b1; resp_o = p_s;
        rd = (d == 1) ? hrdata1 : hrdata0;
      end else begin
        n_stall++;
      end
    end
    if (!done) check("transfer_timeout", done, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; hsel = '0; haddr = '0; hwrite = 1'b0; hsize = HSIZE_WORD;
    hburst = 3'd0; htrans = HTRANS_IDLE; hwdata = '0;
    #1;
    check("rst_ready0", hreadyout0, 1'b1);
    check("rst_resp0",  hresp0,     1'b0);
    check("rst_rdata0", hrdata0,    32'h0);
    check("rst_ready1", hreadyout1, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Word write then read, zero wait.
    xfer(0, 1, 8'h04, HSIZE_WORD, 32'hDEADBEEF, rdat, rsp, frdy, fresp, stalls);
    check("wr04_resp", rsp, 1'b0);
    check("wr04_stall", 32'(stalls), 32'd0);
    xfer(0, 0, 8'h04, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("rd04_data", rdat, 32'hDEADBEEF);
    check("rd04_resp", rsp, 1'b0);
    check("rd04_stall", 32'(stalls), 32'd0);

    // Byte and halfword lanes.
    xfer(0, 1, 8'h04, HSIZE_WORD, 32'h11223344, rdat, rsp, frdy, fresp, stalls);
    xfer(0, 1, 8'h06, HSIZE_BYTE, 32'h00AA0000, rdat, rsp, frdy, fresp, stalls);
    xfer(0, 0, 8'h04, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("byte_write", rdat, 32'h11AA3344);
    xfer(0, 1, 8'h06, HSIZE_HALF, 32'h55660000, rdat, rsp, frdy, fresp, stalls);
    xfer(0, 0, 8'h04, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("half_write", rdat, 32'h55663344);

    // Last legal register, then out-of-range accesses.
    xfer(0, 1, 8'h3C, HSIZE_WORD, 32'hCAFEF00D, rdat, rsp, frdy, fresp, stalls);
    check("wr3c_resp", rsp, 1'b0);
    xfer(0, 0, 8'h40, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("err1_ready", frdy, 1'b0);
    check("err1_resp", fresp, 1'b1);
    check("err2_resp", rsp, 1'b1);
    check("err_stall", 32'(stalls), 32'd1);
    check("err_rdata", rdat, 32'h0);
    xfer(0, 1, 8'h40, HSIZE_WORD, 32'hFFFFFFFF, rdat, rsp, frdy, fresp, stalls);
    check("err_wr_resp", rsp, 1'b1);
    xfer(0, 0, 8'h3C, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("rd3c_after_err", rdat, 32'hCAFEF00D);

    // Misaligned word and oversize transfer are both errors with no write.
    xfer(0, 1, 8'h05, HSIZE_WORD, 32'hFFFFFFFF, rdat, rsp, frdy, fresp, stalls);
    check("misalign_resp", rsp, 1'b1);
    xfer(0, 1, 8'h08, HSIZE_DWORD, 32'hFFFFFFFF, rdat, rsp, frdy, fresp, stalls);
    check("oversize_resp", rsp, 1'b1);
    xfer(0, 0, 8'h04, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("rd04_after_err", rdat, 32'h55663344);
    xfer(0, 0, 8'h08, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("rd08_untouched", rdat, 32'h0);

    // Pipelined write then read of the same register.
    @(posedge clk); #1;
    hsel = 2'b01; htrans = HTRANS_NONSEQ; haddr = 8'h08; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge clk); #1;
    hwrite = 1'b0; hwdata = 32'h5A5A5A5A;
    @(negedge clk);
    check("b2b_wr_ready", hreadyout0, 1'b1);
    @(posedge clk); #1;
    hsel = '0; htrans = HTRANS_IDLE;
    @(negedge clk);
    check("b2b_rd_data", hrdata0, 32'h5A5A5A5A);
    check("b2b_rd_ready", hreadyout0, 1'b1);
    check("b2b_rd_resp", hresp0, 1'b0);

    // IDLE and BUSY with HSEL: no stall, no side effect.
    @(posedge clk); #1;
    hsel = 2'b01; htrans = HTRANS_IDLE; hwrite = 1'b1; haddr = 8'h04;
    @(posedge clk); #1;
    htrans = HTRANS_BUSY; hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("idle_ready", hreadyout0, 1'b1);
    @(posedge clk); #1;
    hsel = '0; htrans = HTRANS_IDLE;
    @(negedge clk);
    check("busy_ready", hreadyout0, 1'b1);
    xfer(0, 0, 8'h04, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("idle_no_write", rdat, 32'h55663344);

    // Three wait states.
    xfer(1, 1, 8'h10, HSIZE_WORD, 32'h12345678, rdat, rsp, frdy, fresp, stalls);
    check("ws_wr_stall", 32'(stalls), 32'd3);
    xfer(1, 0, 8'h10, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("ws_rd_stall", 32'(stalls), 32'd3);
    check("ws_rd_data", rdat, 32'h12345678);
    check("ws_rd_resp", rsp, 1'b0);

    // Reset asserted during WAIT.
    @(posedge clk); #1;
    hsel = 2'b10; htrans = HTRANS_NONSEQ; haddr = 8'h10; hwrite = 1'b0; hsize = HSIZE_WORD;
    @(posedge clk); #1;
    hsel = '0; htrans = HTRANS_IDLE;
    @(negedge clk);
    check("wait_ready_low", hreadyout1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_wait_ready", hreadyout1, 1'b1);
    check("rst_wait_resp", hresp1, 1'b0);
    #1 rst_n = 1'b1;
    xfer(1, 0, 8'h10, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("post_rst_rd1", rdat, 32'h0);
    check("post_rst_stall1", 32'(stalls), 32'd3);
    xfer(0, 0, 8'h04, HSIZE_WORD, 32'h0, rdat, rsp, frdy, fresp, stalls);
    check("post_rst_rd0", rdat, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
